valu_strip_sequencer: RTL
=========================

Name: valu_strip_sequencer

Overview:
- Sequences the vector ALU over operand vectors longer than one ALU word ("chunks" of LANES x DATA_WIDTH).
- Accepts one command via valid/ready, then for each chunk:
  - reads operand 1 and operand 2 from a shared single-port vector memory;
  - drives the external vector ALU with the latched selector;
  - writes the result back to memory.
- Sits between the vector decode/issue stage and the vector register memory. The ALU instance stays outside this block and is wired to its alu_* ports.

Parameters:
- DATA_WIDTH, 8, element width in bits
- LANES, 8, elements per chunk
- SELECTOR_SIZE, 4, ALU operation selector width
- ADDR_WIDTH, 8, chunk address width of the vector memory
- LEN_WIDTH, 8, width of the chunk count field

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_sel  in  SELECTOR_SIZE  ALU op (0100 add, 1100/1101 add/sub, 0101 FP mul, other = pass operand1)
- cmd_src1  in  ADDR_WIDTH  chunk address of operand 1 base
- cmd_src2  in  ADDR_WIDTH  chunk address of operand 2 base
- cmd_dst  in  ADDR_WIDTH  chunk address of result base
- cmd_len  in  LEN_WIDTH  number of chunks; 0 legal
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  memory chunk address
- mem_wdata  out  LANES*DATA_WIDTH  write data (lane 0 in LSBs)
- mem_rdata  in  LANES*DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd
- alu_sel  out  SELECTOR_SIZE  to ALU selector
- alu_op1  out  LANES*DATA_WIDTH  to ALU operand1
- alu_op2  out  LANES*DATA_WIDTH  to ALU operand2
- alu_out  in  LANES*DATA_WIDTH  from ALU (combinational)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset values:
  - state = IDLE;
  - cmd_ready = 1; busy, done, mem_rd, mem_wr = 0;
  - mem_addr, mem_wdata, alu_sel, alu_op1, alu_op2 = 0;
  - chunk index idx = 0; latched command fields = 0.
- Reset mid-command aborts immediately: no further memory strobes, and no done pulse for the aborted command.
- States: IDLE, RD_A, RD_B, EXEC, WR, DONE.
- IDLE:
  - On cmd_valid & cmd_ready, latch sel/src1/src2/dst/len and clear idx.
  - Next state is DONE if len==0, else RD_A.
  - cmd_* is ignored in all other states; cmd_ready = 0 outside IDLE.
- RD_A: mem_rd=1, mem_addr=src1+idx; go to RD_B.
- RD_B: mem_rd=1, mem_addr=src2+idx; register mem_rdata into op1 register; go to EXEC.
- EXEC: register mem_rdata into op2 register; mem_rd=0, mem_wr=0; go to WR.
- WR:
  - mem_wr=1, mem_addr=dst+idx, mem_wdata=alu_out (combinational from op registers).
  - If idx==len-1, go to DONE; else idx++ and go to RD_A.
- DONE: done=1 for exactly this cycle; go to IDLE.
- alu_sel equals the latched sel whenever busy, and 0 in IDLE.
- alu_op1/alu_op2 are the op registers, driven continuously.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap past the top address is legal and silent.
- Timing:
  - Each chunk takes exactly 4 cycles.
  - If a command is accepted at cycle T, done is high at T+1+4*len (len=0 gives T+1).
- Overlapping src and dst regions: chunk k is fully written before chunk k+1 is read, so in-place operation (dst==src1) is correct.
- mem_rd and mem_wr are never both high in the same cycle.

Optional Feature:
- Macro: VALU_SEQ_PERF_CNT_EN.
- Defined: adds output perf_chunks (32 bits), which increments on every WR cycle.
  - Saturates at all-ones.
  - Cleared only by rst; not cleared by new commands.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle:
  - Hold rst 2 cycles with cmd_valid=1 → cmd_ready=1, busy=0, no mem strobes, done=0.
  - After release, the command is accepted on the first cycle.
- Add command, len=3:
  - mem[0x10..0x12] = lanes 1..8, mem[0x20..0x22] = lanes 2 each; sel=0100, dst=0x30.
  - Expect mem[0x30..0x32] = 3..10 per lane, done at T+13, and a strictly RD_A/RD_B/EXEC/WR strobe pattern.
- len=0, sel=0101:
  - No mem_rd/mem_wr at all; done at T+1; cmd_ready back high at T+2.
- In-place FP multiply with wrap:
  - src1=dst=0xFF, src2=0x40, len=2.
  - Expect chunk addresses 0xFF then 0x00, with results equal to reference FP products per lane.
- Reset mid-command:
  - Assert rst during the second chunk's RD_B → next cycle busy=0, no WR to the second dst address, no done pulse.
  - A new command is then accepted normally.
- With VALU_SEQ_PERF_CNT_EN:
  - Two commands, len=3 then len=5 → perf_chunks=8.
  - After rst → perf_chunks=0.

Source files
------------

// File: rtl/valu_strip_sequencer.sv
// Strip-mines one vector ALU command over len chunks: read op1, read op2, execute, write back.
// Optional saturating WR-cycle counter on perf_chunks when VALU_SEQ_PERF_CNT_EN is defined.
module valu_strip_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int LANES         = 8,
    parameter int SELECTOR_SIZE = 4,
    parameter int ADDR_WIDTH    = 8,
    parameter int LEN_WIDTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [SELECTOR_SIZE-1:0]      cmd_sel,
    input  logic [ADDR_WIDTH-1:0]         cmd_src1,
    input  logic [ADDR_WIDTH-1:0]         cmd_src2,
    input  logic [ADDR_WIDTH-1:0]         cmd_dst,
    input  logic [LEN_WIDTH-1:0]          cmd_len,
    output logic                          mem_rd,
    output logic                          mem_wr,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [LANES*DATA_WIDTH-1:0]   mem_wdata,
    input  logic [LANES*DATA_WIDTH-1:0]   mem_rdata,
    output logic [SELECTOR_SIZE-1:0]      alu_sel,
    output logic [LANES*DATA_WIDTH-1:0]   alu_op1,
    output logic [LANES*DATA_WIDTH-1:0]   alu_op2,
    input  logic [LANES*DATA_WIDTH-1:0]   alu_out,
    output logic                          busy,
    output logic                          done
`ifdef VALU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_chunks
`endif
);

    localparam int VW = LANES * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WR, DONE} state_e;

    state_e                   state_q, state_d;
    logic [SELECTOR_SIZE-1:0] sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]    src1_q, src1_d;
    logic [ADDR_WIDTH-1:0]    src2_q, src2_d;
    logic [ADDR_WIDTH-1:0]    dst_q, dst_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [LEN_WIDTH-1:0]     chunkIdx_q, chunkIdx_d;
    logic [VW-1:0]            op1_q, op1_d;
    logic [VW-1:0]            op2_q, op2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            chunkIdx_q <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            chunkIdx_q <= chunkIdx_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
        end
    end

    // Addresses wrap modulo 2^ADDR_WIDTH; the chunk index is truncated to address width.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        dst_d      = dst_q;
        len_d      = len_q;
        chunkIdx_d = chunkIdx_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        alu_sel    = sel_q;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                alu_sel   = '0;
                if (cmd_valid) begin
                    sel_d      = cmd_sel;
                    src1_d     = cmd_src1;
                    src2_d     = cmd_src2;
                    dst_d      = cmd_dst;
                    len_d      = cmd_len;
                    chunkIdx_d = '0;
                    state_d    = (cmd_len == '0) ? DONE : RD_A;
                end
            end
            RD_A: begin
                mem_rd   = 1'b1;
                mem_addr = src1_q + ADDR_WIDTH'(chunkIdx_q);
                state_d  = RD_B;
            end
            RD_B: begin
                mem_rd   = 1'b1;
                mem_addr = src2_q + ADDR_WIDTH'(chunkIdx_q);
                op1_d    = mem_rdata;
                state_d  = EXEC;
            end
            EXEC: begin
                op2_d   = mem_rdata;
                state_d = WR;
            end
            WR: begin
                mem_wr    = 1'b1;
                mem_addr  = dst_q + ADDR_WIDTH'(chunkIdx_q);
                mem_wdata = alu_out;
                if (chunkIdx_q == len_q - LEN_WIDTH'(1)) begin
                    state_d = DONE;
                end else begin
                    chunkIdx_d = chunkIdx_q + LEN_WIDTH'(1);
                    state_d    = RD_A;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_op1 = op1_q;
    assign alu_op2 = op2_q;

`ifdef VALU_SEQ_PERF_CNT_EN
    logic [31:0] perfCnt_q, perfCnt_d;

    always_comb begin
        perfCnt_d = perfCnt_q;
        if (state_q == WR && perfCnt_q != '1) begin
            perfCnt_d = perfCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perfCnt_q <= '0;
        end else begin
            perfCnt_q <= perfCnt_d;
        end
    end

    assign perf_chunks = perfCnt_q;
`endif

endmodule
